// File: rtl/serial_link_ctrl.sv
// Half-duplex direction/strobe sequencer for the serial/parallel converter.
// Define SERIAL_LINK_CTRL_RX_TIMEOUT_EN to build the receive watchdog timer.
module serial_link_ctrl #(
  parameter int PORT_WIDTH = 14,
  parameter int BIT_LENGTH = 4,
  parameter int TURNAROUND = 2,
  parameter int RX_SLACK   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_tx_req,
  input  logic [BIT_LENGTH-1:0] i_tx_len,
  output logic                  o_tx_ack,
  output logic                  o_tx_err,
  output logic                  o_tx_done,
  input  logic                  i_rx_req,
  input  logic [BIT_LENGTH-1:0] i_rx_len,
  output logic                  o_rx_done,
  output logic                  o_rx_timeout,
  output logic                  o_busy,
  output logic                  o_conv_invert_s2p,
  output logic                  o_conv_en,
  output logic                  o_conv_dv_in,
  output logic [BIT_LENGTH-1:0] o_conv_bit_lngt,
  input  logic                  i_conv_dv_out
);

  localparam int CNT_W = (BIT_LENGTH > 4) ? BIT_LENGTH : 4;
  localparam logic [BIT_LENGTH-1:0] PW = BIT_LENGTH'(PORT_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    TX_TURN,
    TX_LOAD,
    TX_SHIFT,
    RX_SHIFT
  } state_t;

  state_t                r_state;
  state_t                w_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt;
  logic [BIT_LENGTH-1:0] r_len;
  logic [BIT_LENGTH-1:0] w_len;
  logic [BIT_LENGTH-1:0] w_lngt;
  logic [BIT_LENGTH-1:0] w_rx_len;
  logic                  w_tx_ok;
  logic                  w_tmr_exp;
  logic                  w_tx_ack;
  logic                  w_tx_err;
  logic                  w_tx_done;
  logic                  w_rx_done;
  logic                  w_rx_to;

  assign w_rx_len = (i_rx_len == '0 || i_rx_len > PW) ? PW : i_rx_len;
  assign w_tx_ok  = (i_tx_len != '0) && (i_tx_len <= PW);

`ifdef SERIAL_LINK_CTRL_RX_TIMEOUT_EN
  localparam int TMR_W = $clog2(PORT_WIDTH + RX_SLACK + 1);
  logic [TMR_W-1:0] r_tmr;

  // Reloaded every idle cycle so it is primed on the accepting edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tmr <= '0;
    end else if (r_state == IDLE) begin
      r_tmr <= TMR_W'(w_rx_len) + TMR_W'(RX_SLACK);
    end else if (r_tmr != '0) begin
      r_tmr <= r_tmr - TMR_W'(1);
    end
  end

  assign w_tmr_exp = (r_tmr == TMR_W'(1));
`else
  logic [31:0] w_unused_slack;
  assign w_unused_slack = RX_SLACK;
  assign w_tmr_exp      = 1'b0;
`endif

  always_comb begin
    w_nxt     = r_state;
    w_cnt     = r_cnt;
    w_len     = r_len;
    w_lngt    = o_conv_bit_lngt;
    w_tx_ack  = 1'b0;
    w_tx_err  = 1'b0;
    w_tx_done = 1'b0;
    w_rx_done = 1'b0;
    w_rx_to   = 1'b0;
    unique case (r_state)
      IDLE: begin
        // A request still high while its error pulse shows is the old one.
        if (i_rx_req) begin
          w_nxt  = RX_SHIFT;
          w_lngt = w_rx_len;
        end else if (i_tx_req && !o_tx_err) begin
          if (w_tx_ok) begin
            w_nxt    = TX_TURN;
            w_len    = i_tx_len;
            w_cnt    = CNT_W'(TURNAROUND - 1);
            w_tx_ack = 1'b1;
          end else begin
            w_tx_err = 1'b1;
          end
        end
      end
      TX_TURN: begin
        if (r_cnt == '0) begin
          w_nxt  = TX_LOAD;
          w_lngt = r_len;
        end else begin
          w_cnt = r_cnt - CNT_W'(1);
        end
      end
      TX_LOAD: begin
        w_nxt = TX_SHIFT;
        w_cnt = CNT_W'(r_len) - CNT_W'(1);
      end
      TX_SHIFT: begin
        if (r_cnt == '0) begin
          w_nxt     = IDLE;
          w_tx_done = 1'b1;
        end else begin
          w_cnt = r_cnt - CNT_W'(1);
        end
      end
      RX_SHIFT: begin
        if (i_conv_dv_out) begin
          w_nxt     = IDLE;
          w_rx_done = 1'b1;
        end else if (w_tmr_exp) begin
          w_nxt   = IDLE;
          w_rx_to = 1'b1;
        end
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state           <= IDLE;
      r_cnt             <= '0;
      r_len             <= '0;
      o_tx_ack          <= 1'b0;
      o_tx_err          <= 1'b0;
      o_tx_done         <= 1'b0;
      o_rx_done         <= 1'b0;
      o_rx_timeout      <= 1'b0;
      o_busy            <= 1'b0;
      o_conv_invert_s2p <= 1'b1;
      o_conv_en         <= 1'b0;
      o_conv_dv_in      <= 1'b0;
      o_conv_bit_lngt   <= '0;
    end else begin
      r_state           <= w_nxt;
      r_cnt             <= w_cnt;
      r_len             <= w_len;
      o_tx_ack          <= w_tx_ack;
      o_tx_err          <= w_tx_err;
      o_tx_done         <= w_tx_done;
      o_rx_done         <= w_rx_done;
      o_rx_timeout      <= w_rx_to;
      o_busy            <= (w_nxt != IDLE);
      o_conv_invert_s2p <= !(w_nxt inside {TX_TURN, TX_LOAD, TX_SHIFT});
      o_conv_en         <= (w_nxt == RX_SHIFT);
      o_conv_dv_in      <= (w_nxt == TX_LOAD);
      o_conv_bit_lngt   <= w_lngt;
    end
  end

endmodule
